calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_calc_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven controller for a two-operand add/subtract calculator.
// Builds decimal operands from key strobes, hands them to an external ALU and shows the result.
module calc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic [W-1:0] alu_num1,
    output logic [W-1:0] alu_num2,
    output logic         alu_op,
    output logic         alu_start,
    input  logic [W-1:0] alu_res,
    input  logic         alu_valid,
    output logic [W-1:0] display,
    output logic         busy,
    output logic         error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [W+3:0] TEN = (W+4)'(32'd10);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        EXEC    = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t         state_r, state_s;
    logic [W-1:0]   a_r, a_s;
    logic [W-1:0]   b_r, b_s;
    logic           op_r, op_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [W-1:0]   display_r, display_s;
    logic           start_r, busy_r, error_r;

    logic is_digit_s, is_arith_s, is_eq_s, is_clr_s, is_sub_s;

    // Appends a decimal digit; a digit that would overflow W bits is dropped.
    function automatic logic [W-1:0] append_digit(input logic [W-1:0] cur, input logic [3:0] d);
        logic [W+3:0] ext;
        ext = ({4'd0, cur} * TEN) + {{W{1'b0}}, d};
        if (ext > {4'd0, {W{1'b1}}}) begin
            append_digit = cur;
        end else begin
            append_digit = ext[W-1:0];
        end
    endfunction

    assign is_digit_s = key_valid && (key_code <= 4'd9);
    assign is_arith_s = key_valid && ((key_code == 4'd10) || (key_code == 4'd11));
    assign is_eq_s    = key_valid && (key_code == 4'd12);
    assign is_clr_s   = key_valid && (key_code == 4'd13);
    assign is_sub_s   = (key_code == 4'd11);

    // Next-state and datapath update; clear overrides everything, including a result arriving.
    always_comb begin
        state_s   = state_r;
        a_s       = a_r;
        b_s       = b_r;
        op_s      = op_r;
        timer_s   = timer_r;
        display_s = display_r;
        if (is_clr_s) begin
            state_s   = ENTER_A;
            a_s       = {W{1'b0}};
            b_s       = {W{1'b0}};
            op_s      = 1'b0;
            timer_s   = {TW{1'b0}};
            display_s = {W{1'b0}};
        end else begin
            case (state_r)
                ENTER_A: begin
                    if (is_digit_s) begin
                        a_s       = append_digit(a_r, key_code);
                        display_s = a_s;
                    end else if (is_arith_s) begin
                        op_s      = is_sub_s;
                        b_s       = {W{1'b0}};
                        display_s = {W{1'b0}};
                        state_s   = ENTER_B;
                    end else begin
                        state_s = ENTER_A;
                    end
                end
                ENTER_B: begin
                    if (is_digit_s) begin
                        b_s       = append_digit(b_r, key_code);
                        display_s = b_s;
                    end else if (is_arith_s) begin
                        op_s = is_sub_s;
                    end else if (is_eq_s) begin
                        state_s = EXEC;
                    end else begin
                        state_s = ENTER_B;
                    end
                end
                EXEC: begin
                    state_s = WAIT;
                    timer_s = {TW{1'b0}};
                end
                WAIT: begin
                    if (alu_valid) begin
                        a_s       = alu_res;
                        display_s = alu_res;
                        state_s   = SHOW;
                    end else if (timer_r == TW'(TIMEOUT - 1)) begin
                        display_s = {W{1'b1}};
                        state_s   = ERR;
                    end else begin
                        timer_s = timer_r + TW'(1'b1);
                    end
                end
                SHOW: begin
                    // The result stays in a, so add/sub chains it and equals repeats the last op.
                    if (is_digit_s) begin
                        a_s       = {{(W-4){1'b0}}, key_code};
                        display_s = {{(W-4){1'b0}}, key_code};
                        state_s   = ENTER_A;
                    end else if (is_arith_s) begin
                        op_s    = is_sub_s;
                        b_s     = {W{1'b0}};
                        state_s = ENTER_B;
                    end else if (is_eq_s) begin
                        state_s = EXEC;
                    end else begin
                        state_s = SHOW;
                    end
                end
                ERR: begin
                    state_s = ERR;
                end
                default: begin
                    state_s = ENTER_A;
                end
            endcase
        end
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ENTER_A;
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            op_r      <= 1'b0;
            timer_r   <= {TW{1'b0}};
            display_r <= {W{1'b0}};
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            b_r       <= b_s;
            op_r      <= op_s;
            timer_r   <= timer_s;
            display_r <= display_s;
            start_r   <= (state_s == EXEC);
            busy_r    <= (state_s == EXEC) || (state_s == WAIT);
            error_r   <= (state_s == ERR);
        end
    end

    assign alu_num1  = a_r;
    assign alu_num2  = b_r;
    assign alu_op    = op_r;
    assign alu_start = start_r;
    assign display   = display_r;
    assign busy      = busy_r;
    assign error     = error_r;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed scenarios plus randomized key/ALU-latency traffic for calc_ctrl,
// compared every cycle against a calculator-level model of the keypad behaviour.
module tb_calc_ctrl;
    localparam int W       = 16;
    localparam int TIMEOUT = 16;
    localparam int MA = 0, MB = 1, MX = 2, MW = 3, MS = 4, ME = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] alu_num1, alu_num2, alu_res, display;
    logic         alu_op, alu_start, alu_valid, busy, error;

    int errors = 0;
    int checks = 0;
    int n_start, n_busy;

    always #5 clk = ~clk;

    calc_ctrl #(.TIMEOUT(TIMEOUT), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op), .alu_start(alu_start),
        .alu_res(alu_res), .alu_valid(alu_valid), .display(display), .busy(busy), .error(error)
    );

    // ALU model: result latched at the start pulse, valid after alu_lat further cycles.
    int           alu_lat   = 0;
    bit           alu_never = 1'b0;
    bit           alu_pend  = 1'b0;
    int           alu_cnt   = 0;
    logic [W-1:0] alu_q     = '0;

    always @(posedge clk) begin
        if (alu_start) begin
            alu_pend <= !alu_never;
            alu_cnt  <= alu_lat;
            alu_q    <= alu_op ? (alu_num1 - alu_num2) : (alu_num1 + alu_num2);
        end else if (alu_pend) begin
            if (alu_cnt == 0) alu_pend <= 1'b0;
            else              alu_cnt  <= alu_cnt - 1;
        end
    end
    assign alu_valid = alu_pend && (alu_cnt == 0);
    assign alu_res   = alu_q;

    // Calculator-level reference model
    int           m_mode;
    logic [W-1:0] m_a, m_b, m_disp;
    bit           m_op;
    int           m_wait;

    function automatic logic [W-1:0] m_digit(input logic [W-1:0] x, input int d);
        int t;
        t = int'(x) * 10 + d;
        if (t > (1 << W) - 1) return x;
        return t[W-1:0];
    endfunction

    task automatic model_reset();
        m_mode = MA; m_a = '0; m_b = '0; m_op = 1'b0; m_disp = '0; m_wait = 0;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit av, input logic [W-1:0] ar);
        bit dig, ari, eq;
        dig = kv && kc <= 9;
        ari = kv && (kc == 10 || kc == 11);
        eq  = kv && kc == 12;
        if (kv && kc == 13) begin
            model_reset();
            return;
        end
        case (m_mode)
            MA: if (dig) begin m_a = m_digit(m_a, kc); m_disp = m_a; end
                else if (ari) begin m_op = (kc == 11); m_b = '0; m_disp = '0; m_mode = MB; end
            MB: if (dig) begin m_b = m_digit(m_b, kc); m_disp = m_b; end
                else if (ari) m_op = (kc == 11);
                else if (eq) m_mode = MX;
            MX: begin m_mode = MW; m_wait = 0; end
            MW: if (av) begin m_a = ar; m_disp = ar; m_mode = MS; end
                else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin m_mode = ME; m_disp = '1; end
                end
            MS: if (dig) begin m_a = W'(kc); m_disp = W'(kc); m_mode = MA; end
                else if (ari) begin m_op = (kc == 11); m_b = '0; m_mode = MB; end
                else if (eq) m_mode = MX;
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("alu_num1", alu_num1, m_a);
        chk("alu_num2", alu_num2, m_b);
        chk("alu_op", alu_op, m_op);
        chk("alu_start", alu_start, m_mode == MX);
        chk("display", display, m_disp);
        chk("busy", busy, m_mode == MX || m_mode == MW);
        chk("error", error, m_mode == ME);
        if (alu_start) n_start++;
        if (busy) n_busy++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_num1"}, alu_num1, 0);
        chk({tag, "_num2"}, alu_num2, 0);
        chk({tag, "_op"}, alu_op, 0);
        chk({tag, "_start"}, alu_start, 0);
        chk({tag, "_display"}, display, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input bit kv, input logic [3:0] kc);
        bit           av;
        logic [W-1:0] ar;
        key_valid = kv;
        key_code  = kc;
        #1;
        av = alu_valid;
        ar = alu_res;
        @(posedge clk);
        model_step(kv, kc, av, ar);
        @(negedge clk);
        key_valid = 1'b0;
        compare_all();
    endtask

    task automatic key(input logic [3:0] kc);
        tick(1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
    endtask

    // Reset pulse in the middle of the low clock phase; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        n_start = 0; n_busy = 0;
        model_reset();
        #12 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // 12 + 34
        alu_lat = 0;
        key(4'd1); key(4'd2); key(4'd10); key(4'd3); key(4'd4);
        chk("op_a", alu_num1, 12); chk("op_b", alu_num2, 34); chk("op_sum", alu_op, 0);
        n_start = 0; n_busy = 0;
        key(4'd12); idle(2);
        chk("sum_46", display, 46);
        chk("start_pulses", n_start, 1);
        chk("busy_cycles", n_busy, 2);

        // repeated equals then subtract chain
        key(4'd12); idle(2); chk("rep_80", display, 80);
        key(4'd12); idle(2); chk("rep_114", display, 114);
        key(4'd11); key(4'd1); key(4'd4); key(4'd12); idle(2);
        chk("sub_100", display, 100);

        // operand overflow boundary
        key(4'd13);
        key(4'd6); key(4'd5); key(4'd5); key(4'd3); key(4'd5);
        chk("max_65535", alu_num1, 65535);
        key(4'd9); chk("ovf_ignored", alu_num1, 65535);
        key(4'd13);
        key(4'd6); key(4'd5); key(4'd5); key(4'd3); key(4'd6);
        chk("ovf_6553", alu_num1, 6553);

        // ALU timeout
        alu_never = 1'b1;
        key(4'd13); key(4'd1); key(4'd10); key(4'd2); key(4'd12); idle(1);
        idle(TIMEOUT - 1); chk("no_err_early", error, 0);
        idle(1); chk("timeout_err", error, 1); chk("timeout_disp", display, 16'hFFFF);
        key(4'd13); chk("clr_err", error, 0); chk("clr_disp", display, 0);
        alu_never = 1'b0;

        // key dropped during WAIT
        alu_lat = 4;
        key(4'd13); key(4'd2); key(4'd10); key(4'd3); key(4'd12); idle(1);
        key(4'd7); idle(6);
        chk("drop_disp", display, 5); chk("drop_a", alu_num1, 5);

        // clear coinciding with alu_valid
        alu_lat = 2;
        key(4'd13); key(4'd4); key(4'd10); key(4'd5); key(4'd12); idle(1); idle(2);
        chk("valid_coincident", alu_valid, 1);
        key(4'd13); chk("clr_valid_a", alu_num1, 0); chk("clr_valid_disp", display, 0);

        // reset during WAIT, late valid ignored
        alu_lat = 3;
        key(4'd1); key(4'd10); key(4'd1); key(4'd12); idle(1);
        async_reset("rst_wait");
        idle(6); chk("late_valid_a", alu_num1, 0); chk("late_valid_disp", display, 0);

        // reset mid-entry
        key(4'd3); key(4'd10); key(4'd4);
        async_reset("rst_entry");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          kv;
            logic [3:0]  kc;
            alu_lat   = $urandom_range(0, TIMEOUT + 2);
            alu_never = ($urandom_range(0, 19) == 0);
            kv = ($urandom_range(0, 2) != 0);
            kc = 4'($urandom_range(0, 15));
            if (kc == 4'd13 && $urandom_range(0, 3) != 0) kc = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 499) == 0) async_reset("rst_rand");
            else tick(kv, kc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
